// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared MIPS16 datapath widths, types and constants
package mips16_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - pending-write busy bitmap with set-over-clear priority
// and read-port hazard evaluation (bypass hits supplied by the top level)
module scoreboard #(
  parameter int ADDR_W   = mips16_pkg::REG_ADDR_W,
  parameter int NUM_REGS = mips16_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IssueEn,
  input  logic [ADDR_W-1:0]   IssueAddr,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic                RdEn1,
  input  logic [ADDR_W-1:0]   RdAddr1,
  input  logic                RdEn2,
  input  logic [ADDR_W-1:0]   RdAddr2,
  input  logic                BypHit1,
  input  logic                BypHit2,
  output logic [NUM_REGS-1:0] Busy,
  output logic                Stall
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(mips16_pkg::REG_ZERO);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_haz1;
  logic                w_haz2;
  logic                w_issue;

  assign w_haz1  = RdEn1 & r_busy[RdAddr1] & ~BypHit1;
  assign w_haz2  = RdEn2 & r_busy[RdAddr2] & ~BypHit2;
  assign Stall   = w_haz1 | w_haz2;
  assign w_issue = IssueEn & ~Stall;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue && IssueAddr != ZERO_ADDR) w_set[IssueAddr] = 1'b1;
    if (WrEn && WrAddr != ZERO_ADDR)       w_clr[WrAddr]    = 1'b1;
    // A newer producer owns the register, so its set beats the old writeback's clear.
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign Busy = r_busy;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file (r0 = 0) with pending-write
// scoreboard; define REGFILE_BYPASS_EN to compile in write-through forwarding
module regfile_scoreboard #(
  parameter int DATA_W   = mips16_pkg::DATA_W,
  parameter int ADDR_W   = mips16_pkg::REG_ADDR_W,
  parameter int NUM_REGS = mips16_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   RdAddr1,
  input  logic [ADDR_W-1:0]   RdAddr2,
  input  logic                RdEn1,
  input  logic                RdEn2,
  output logic [DATA_W-1:0]   RdData1,
  output logic [DATA_W-1:0]   RdData2,
  input  logic                WrEn,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic [DATA_W-1:0]   WrData,
  input  logic                IssueEn,
  input  logic [ADDR_W-1:0]   IssueAddr,
  output logic                Stall,
  output logic [NUM_REGS-1:0] Busy
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(mips16_pkg::REG_ZERO);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_rd1_stored;
  logic [DATA_W-1:0] w_rd2_stored;
  logic              w_byp1;
  logic              w_byp2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (WrEn && WrAddr != ZERO_ADDR) begin
      r_regs[WrAddr] <= WrData;
    end
  end

  assign w_rd1_stored = (RdAddr1 == ZERO_ADDR) ? '0 : r_regs[RdAddr1];
  assign w_rd2_stored = (RdAddr2 == ZERO_ADDR) ? '0 : r_regs[RdAddr2];

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = WrEn && (WrAddr == RdAddr1) && (RdAddr1 != ZERO_ADDR);
  assign w_byp2 = WrEn && (WrAddr == RdAddr2) && (RdAddr2 != ZERO_ADDR);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign RdData1 = w_byp1 ? WrData : w_rd1_stored;
  assign RdData2 = w_byp2 ? WrData : w_rd2_stored;

  scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .RdEn1     (RdEn1),
    .RdAddr1   (RdAddr1),
    .RdEn2     (RdEn2),
    .RdAddr2   (RdAddr2),
    .BypHit1   (w_byp1),
    .BypHit2   (w_byp2),
    .Busy      (Busy),
    .Stall     (Stall)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized bench for regfile_scoreboard
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  RdAddr1 = '0, RdAddr2 = '0, WrAddr = '0, IssueAddr = '0;
  logic        RdEn1 = 1'b0, RdEn2 = 1'b0, WrEn = 1'b0, IssueEn = 1'b0;
  logic [15:0] WrData = '0;
  logic [15:0] RdData1, RdData2;
  logic        Stall;
  logic [31:0] Busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_regs [32];
  bit          m_busy [32];

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .RdEn1(RdEn1), .RdEn2(RdEn2),
    .RdData1(RdData1), .RdData2(RdData2),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr),
    .Stall(Stall), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit fwd(input logic [4:0] a);
    return BYP && WrEn && (WrAddr == a) && (a != 0);
  endfunction

  function automatic logic [15:0] m_read(input logic [4:0] a);
    if (a == 0) return 16'h0;
    if (fwd(a)) return WrData;
    return m_regs[a];
  endfunction

  function automatic bit m_stall();
    bit s1, s2;
    s1 = RdEn1 && m_busy[RdAddr1] && !fwd(RdAddr1);
    s2 = RdEn2 && m_busy[RdAddr2] && !fwd(RdAddr2);
    return s1 || s2;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    RdEn1 = 0; RdEn2 = 0; WrEn = 0; IssueEn = 0;
    RdAddr1 = 0; RdAddr2 = 0; WrAddr = 0; IssueAddr = 0; WrData = 0;
  endtask

  // Compare against the model mid-cycle, then apply the edge to the model.
  task automatic cycle();
    bit st;
    @(negedge clk);
    st = m_stall();
    check("rd1", RdData1, m_read(RdAddr1));
    check("rd2", RdData2, m_read(RdAddr2));
    check("stall", Stall, st);
    check("busy", Busy, m_busy_vec());
    @(posedge clk);
    if (WrEn && WrAddr != 0) begin
      m_regs[WrAddr] = WrData;
      m_busy[WrAddr] = 1'b0;
    end
    if (IssueEn && !st && IssueAddr != 0) m_busy[IssueAddr] = 1'b1;
    #1;
  endtask

  task automatic midcycle_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_clear();
    check("rst_busy", Busy, 32'h0);
    check("rst_rd1", RdData1, m_read(RdAddr1));
    check("rst_stall", Stall, m_stall());
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    m_clear();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", Busy, 32'h0);
    check("reset_stall", Stall, 1'b0);

    // write r5, read it back next cycle
    WrEn = 1; WrAddr = 5; WrData = 16'h1234;
    cycle();
    idle(); RdAddr1 = 5; #1;
    check("r5_read", RdData1, 16'h1234);
    check("r5_busy", Busy, 32'h0);

    // writes to r0 are discarded
    WrEn = 1; WrAddr = 0; WrData = 16'hFFFF;
    cycle();
    idle(); RdAddr1 = 0; #1;
    check("r0_read", RdData1, 16'h0);
    check("r0_busy", Busy[0], 1'b0);

    // load-use stall; issue during stall is ignored
    IssueEn = 1; IssueAddr = 3;
    cycle();
    idle(); RdEn1 = 1; RdAddr1 = 3; IssueEn = 1; IssueAddr = 4; #1;
    check("r3_stall", Stall, 1'b1);
    cycle();
    check("stall_issue_ignored", Busy, 32'h0000_0008);

    // writeback of r3 while it is being read
    IssueEn = 0; WrEn = 1; WrAddr = 3; WrData = 16'h00AB; #1;
    check("wb_stall", Stall, BYP ? 1'b0 : 1'b1);
    if (BYP) check("wb_bypass", RdData1, 16'h00AB);
    cycle();
    WrEn = 0; #1;
    check("after_wb_stall", Stall, 1'b0);
    check("after_wb_rd", RdData1, 16'h00AB);

    // same-edge issue and writeback of r7: set wins, data still lands
    idle(); IssueEn = 1; IssueAddr = 7; WrEn = 1; WrAddr = 7; WrData = 16'h5A5A;
    cycle();
    idle(); RdAddr2 = 7; #1;
    check("r7_busy", Busy[7], 1'b1);
    check("r7_data", RdData2, 16'h5A5A);
    WrEn = 1; WrAddr = 7; WrData = 16'h1111;
    cycle();
    idle();

    // reset while r9 is pending
    WrEn = 1; WrAddr = 9; WrData = 16'h0099;
    cycle();
    idle(); IssueEn = 1; IssueAddr = 9;
    cycle();
    idle(); RdEn1 = 1; RdAddr1 = 9; #1;
    check("r9_stall", Stall, 1'b1);
    midcycle_reset();
    check("r9_after_rst_rd", RdData1, 16'h0);
    check("r9_after_rst_stall", Stall, 1'b0);
    WrEn = 1; WrAddr = 9; WrData = 16'h0042;
    cycle();
    idle(); #1;
    check("late_wb_busy", Busy, 32'h0);

    // randomized traffic, addresses biased toward a few registers for hazards
    for (int n = 0; n < 600; n++) begin
      RdEn1     = $urandom_range(0, 3) != 0;
      RdEn2     = $urandom_range(0, 1);
      RdAddr1   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      RdAddr2   = 5'($urandom_range(0, 7));
      WrEn      = $urandom_range(0, 2) == 0;
      WrAddr    = 5'($urandom_range(0, 7));
      WrData    = 16'($urandom);
      IssueEn   = $urandom_range(0, 2) == 0;
      IssueAddr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 79) == 0) midcycle_reset();
      else cycle();
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
